// File: rtl/load_store_seq.sv
// Sequencer for byte/half/word loads and stores against a fixed-latency memory.
// Sub-word stores are read-modify-write; misaligned or illegal requests raise addr_exc.
module load_store_seq #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              addr_exc
);

    localparam int NB    = DATA_W / 8;
    localparam int LW    = $clog2(NB);
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_WRITE,
        S_DONE,
        S_EXC
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op_store;
    logic [1:0]         r_size;
    logic               r_sign_ext;
    logic [LW-1:0]      r_lane;
    logic [DATA_W-1:0]  r_wdata;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               w_misalign;
    logic               w_last;
    logic               w_accept;
    logic               w_store_word;

    // Pull the addressed byte/half down to bit 0 and extend it to DATA_W.
    function automatic logic [DATA_W-1:0] f_extract(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        sz,
        input logic [LW-1:0]     lane,
        input logic              sx
    );
        logic [DATA_W-1:0] sh;
        sh = d >> {lane, 3'b000};
        case (sz)
            2'b00:   return sx ? {{(DATA_W-8){sh[7]}}, sh[7:0]}
                               : {{(DATA_W-8){1'b0}}, sh[7:0]};
            2'b01:   return sx ? {{(DATA_W-16){sh[15]}}, sh[15:0]}
                               : {{(DATA_W-16){1'b0}}, sh[15:0]};
            default: return d;
        endcase
    endfunction

    // Overlay the low byte/half of wd onto the addressed lanes of d.
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0] d,
        input logic [DATA_W-1:0] wd,
        input logic [1:0]        sz,
        input logic [LW-1:0]     lane
    );
        logic [DATA_W-1:0] m;
        m = (sz == 2'b00) ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF);
        return (d & ~(m << {lane, 3'b000})) | ((wd & m) << {lane, 3'b000});
    endfunction

    assign w_misalign   = (size == 2'b11) ||
                          (size == 2'b01 && addr[0]) ||
                          (size == 2'b10 && addr[LW-1:0] != '0);
    assign w_store_word = op_store && (size == 2'b10);
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_last       = (r_cnt == CNT_W'(MEM_LAT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_misalign)        w_next = S_EXC;
                    else if (w_store_word) w_next = S_WRITE;
                    else                   w_next = S_READ_WAIT;
                end
            end
            S_READ_WAIT: if (w_last) w_next = r_op_store ? S_WRITE : S_DONE;
            S_WRITE:     w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            S_EXC:       w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE) || (r_state == S_EXC);
        addr_exc = (r_state == S_EXC);
        mem_wr   = (r_state == S_WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_op_store  <= 1'b0;
            r_size      <= 2'b00;
            r_sign_ext  <= 1'b0;
            r_lane      <= '0;
            r_wdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_cnt <= (r_state == S_READ_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_op_store <= op_store;
                r_size     <= size;
                r_sign_ext <= sign_ext;
                r_lane     <= addr[LW-1:0];
                r_wdata    <= wdata;
                r_mem_addr <= {addr[ADDR_W-1:LW], {LW{1'b0}}};
                if (w_store_word && !w_misalign) r_mem_wdata <= wdata;
            end
            if (r_state == S_READ_WAIT && w_last) begin
                if (r_op_store) r_mem_wdata <= f_merge(mem_rdata, r_wdata, r_size, r_lane);
                else            r_rdata     <= f_extract(mem_rdata, r_size, r_lane, r_sign_ext);
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;

endmodule

// File: doc/load_store_seq.md
LOAD_STORE_SEQ -- requirements
Module: load_store_seq

Interface
REQ-001 Parameter DATA_W, default 32, memory/register data width; multiple of 8, 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter MEM_LAT, default 3, memory read latency in cycles; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request strobe; accepted only in IDLE.
REQ-007 op_store  in  1  1 = store, 0 = load.
REQ-008 size  in  2  00 byte, 01 half, 10 full DATA_W word, 11 illegal.
REQ-009 sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-010 addr  in  ADDR_W  byte address.
REQ-011 wdata  in  DATA_W  store data, right-aligned.
REQ-012 mem_rdata  in  DATA_W  memory read data.
REQ-013 mem_addr  out  ADDR_W  aligned memory address, registered.
REQ-014 mem_wr  out  1  memory write enable, 1 = write, 0 = read.
REQ-015 mem_wdata  out  DATA_W  memory write data, registered.
REQ-016 rdata  out  DATA_W  extended load result, registered.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 addr_exc  out  1  one-cycle pulse on misaligned or illegal request.

Function
REQ-020 The block SHALL latch op_store, size, sign_ext, addr and wdata when start=1 in IDLE.
REQ-021 start outside IDLE SHALL be ignored, including in the DONE cycle.
REQ-022 Lane index L = addr[log2(DATA_W/8)-1:0]; mem_addr SHALL be addr with those bits cleared, held for the whole operation.
REQ-023 The FSM SHALL have these states: IDLE, READ_WAIT, WRITE, DONE, EXC.
REQ-024 IDLE+start SHALL branch on the latched request:
  - size=11, half with addr[0]=1, or word with L!=0 -> EXC;
  - store word -> WRITE;
  - any other request -> READ_WAIT.
REQ-025 READ_WAIT SHALL:
  - drive mem_wr=0;
  - run a counter from 0 to MEM_LAT-1;
  - sample mem_rdata in the cycle the counter equals MEM_LAT-1.
REQ-026 Load exit from READ_WAIT SHALL extract the result and go to DONE:
  - byte = mem_rdata[8L+7:8L];
  - half = bits at lane L..L+1;
  - word = all of mem_rdata;
  - extend to DATA_W per sign_ext and register into rdata.
REQ-027 Sub-word store exit from READ_WAIT SHALL replace only the addressed byte or half lanes of mem_rdata with wdata's low bits, register the result into mem_wdata, and go to WRITE.
REQ-028 WRITE SHALL last exactly one cycle with mem_wr=1 and mem_wdata stable, then go to DONE; a store word sets mem_wdata=wdata.
REQ-029 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-030 EXC SHALL assert addr_exc=1 and done=1 for one cycle, then return to IDLE, with:
  - no memory access;
  - mem_wr=0;
  - rdata unchanged.
REQ-031 Latency, counted from the start-accept edge: load done at cycle MEM_LAT+1; sub-word store done at MEM_LAT+2; word store done at 2; EXC at 1.
REQ-032 rdata SHALL hold its value until the next completed load; stores SHALL NOT modify rdata.
REQ-033 mem_wr SHALL be 1 only in WRITE.

Reset
REQ-034 reset=1 SHALL immediately force the following, regardless of clk:
  - state to IDLE and counter to 0;
  - mem_wr, busy, done, addr_exc to 0;
  - mem_addr, mem_wdata, rdata to 0.
REQ-035 Reset during any state, including WRITE, SHALL abort the operation with no further memory write; the first start after release SHALL behave normally.

Verification (DATA_W=32, MEM_LAT=3)
REQ-036 Load byte, signed, addr 0x103, mem_rdata 0x80FF1234 -> mem_addr 0x100, rdata 0xFFFFFF80, done at cycle 4.
REQ-037 Load half, unsigned, addr 0x102, mem_rdata 0x80015678 -> rdata 0x00008001, done at cycle 4.
REQ-038 Store byte, addr 0x201, wdata 0x000000AB, mem_rdata 0x11223344 -> mem_wr=1 with mem_wdata 0x1122AB44 at cycle 4, done at cycle 5.
REQ-039 Load word, addr 0x302 -> addr_exc=1 and done=1 at cycle 1, mem_wr never 1, rdata unchanged.
REQ-040 Reset pulse in READ_WAIT cycle 2 -> busy/done/mem_wr drop immediately; a following store word to 0x400 completes with done at cycle 2.
REQ-041 start held high throughout a load -> exactly one operation per IDLE acceptance; starts in busy cycles have no effect.
